// File: rtl/uc_movimento_pkg.sv
// Shared definitions for the elevator movement control unit: state codes,
// default sizing, direction constants and a floor-range helper.
package uc_movimento_pkg;

  localparam int NUM_ANDARES_DEF = 8;
  localparam int CAPACIDADE_DEF  = 4;
  localparam int T_ESPERA_DEF    = 50;
  localparam int T_VIAGEM_DEF    = 1000;

  localparam logic SOBE  = 1'b1;
  localparam logic DESCE = 1'b0;

  // The numeric codes are visible on db_estado, so they are fixed here.
  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    INICIALIZA  = 4'd1,
    PROX_PEDIDO = 4'd2,
    SUBINDO     = 4'd3,
    DESCENDO    = 4'd4,
    REGISTRA    = 4'd5,
    CHECA       = 4'd6,
    ENTRA       = 4'd7,
    SAI         = 4'd8,
    REJEITA     = 4'd9,
    SHIFT       = 4'd10,
    AGUARDA     = 4'd11,
    ERRO        = 4'd12
  } estado_t;

  // Compared at 32 bits so power-of-two floor counts do not fold to a constant.
  function automatic logic andar_valido(input int unsigned andar,
                                        input int unsigned num_andares);
    return andar < num_andares;
  endfunction

endpackage

// File: rtl/uc_movimento_multi_detector_borda.sv
// Rising-edge detector: one sample register plus AND-NOT. Shared by any
// sensor input that needs a single-cycle pulse per low-to-high transition.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic borda
);

  logic sinal_q, sinal_d;

  always_comb sinal_d = sinal;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sinal_q <= 1'b0;
    else        sinal_q <= sinal_d;
  end

  assign borda = sinal & ~sinal_q;

endmodule

// File: rtl/uc_movimento_multi.sv
// N-floor elevator movement control unit with capacity limit and request
// rejection. Define UC_MOVIMENTO_WATCHDOG_EN to add the travel watchdog.
module uc_movimento_multi
  import uc_movimento_pkg::*;
#(
  parameter int NUM_ANDARES = NUM_ANDARES_DEF,
  parameter int CAPACIDADE  = CAPACIDADE_DEF,
  parameter int T_ESPERA    = T_ESPERA_DEF,
  parameter int T_VIAGEM    = T_VIAGEM_DEF,
  localparam int ANDAR_W    = $clog2(NUM_ANDARES),
  localparam int CARGA_W    = $clog2(CAPACIDADE + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic [ANDAR_W-1:0] andar_inicial,
  input  logic               temDestino,
  input  logic [ANDAR_W-1:0] destino,
  input  logic               eh_origem,
  input  logic               sensorAndar,
  output logic               shift,
  output logic               motorSubindo,
  output logic               motorDescendo,
  output logic               coloca_objetos,
  output logic               tira_objetos,
  output logic               rejeita,
  output logic [ANDAR_W-1:0] andar_atual,
  output logic [CARGA_W-1:0] carga,
  output logic               erro,
  output logic [3:0]         db_estado
);

  if (NUM_ANDARES < 2 || CAPACIDADE < 1 || T_ESPERA < 1 || T_VIAGEM < 1) begin : g_param_chk
    $error("uc_movimento_multi: invalid parameter set");
  end

  localparam logic [ANDAR_W-1:0] TOPO    = ANDAR_W'(NUM_ANDARES - 1);
  localparam logic [CARGA_W-1:0] CAP     = CARGA_W'(CAPACIDADE);
  localparam int                 ESP_W   = $clog2(T_ESPERA + 1);
  localparam logic [ESP_W-1:0]   ESP_FIM = ESP_W'(T_ESPERA - 1);

  estado_t            estado_q, estado_d;
  logic [ANDAR_W-1:0] andar_q, andar_d;
  logic [CARGA_W-1:0] carga_q, carga_d;
  logic [ANDAR_W-1:0] destino_q, destino_d;
  logic               origem_q, origem_d;
  logic               dir_q, dir_d;
  logic [ESP_W-1:0]   espera_q, espera_d;
  logic               borda;

`ifdef UC_MOVIMENTO_WATCHDOG_EN
  localparam int               VIA_W   = $clog2(T_VIAGEM + 1);
  localparam logic [VIA_W-1:0] VIA_FIM = VIA_W'(T_VIAGEM - 1);
  logic             erro_q, erro_d;
  logic [VIA_W-1:0] viagem_q, viagem_d;
`endif

  detector_borda u_borda (
    .clock (clock),
    .reset (reset),
    .sinal (sensorAndar),
    .borda (borda)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      andar_q   <= '0;
      carga_q   <= '0;
      destino_q <= '0;
      origem_q  <= 1'b0;
      dir_q     <= DESCE;
      espera_q  <= '0;
`ifdef UC_MOVIMENTO_WATCHDOG_EN
      erro_q    <= 1'b0;
      viagem_q  <= '0;
`endif
    end else begin
      estado_q  <= estado_d;
      andar_q   <= andar_d;
      carga_q   <= carga_d;
      destino_q <= destino_d;
      origem_q  <= origem_d;
      dir_q     <= dir_d;
      espera_q  <= espera_d;
`ifdef UC_MOVIMENTO_WATCHDOG_EN
      erro_q    <= erro_d;
      viagem_q  <= viagem_d;
`endif
    end
  end

  always_comb begin
    estado_d       = estado_q;
    andar_d        = andar_q;
    carga_d        = carga_q;
    destino_d      = destino_q;
    origem_d       = origem_q;
    dir_d          = dir_q;
    espera_d       = espera_q;
`ifdef UC_MOVIMENTO_WATCHDOG_EN
    erro_d         = erro_q;
    // Cleared outside motion and on every edge, so each leg starts from 0.
    viagem_d       = '0;
`endif
    shift          = 1'b0;
    motorSubindo   = 1'b0;
    motorDescendo  = 1'b0;
    coloca_objetos = 1'b0;
    tira_objetos   = 1'b0;
    rejeita        = 1'b0;

    case (estado_q)
      INICIAL: if (iniciar) estado_d = INICIALIZA;

      INICIALIZA: begin
        carga_d  = '0;
`ifdef UC_MOVIMENTO_WATCHDOG_EN
        erro_d   = 1'b0;
`endif
        andar_d  = andar_valido(32'(andar_inicial), NUM_ANDARES) ? andar_inicial : '0;
        estado_d = PROX_PEDIDO;
      end

      PROX_PEDIDO: if (temDestino) begin
        destino_d = destino;
        origem_d  = eh_origem;
        dir_d     = (destino > andar_q) ? SOBE : DESCE;
        if (!andar_valido(32'(destino), NUM_ANDARES)) estado_d = REJEITA;
        else if (destino == andar_q)                  estado_d = CHECA;
        else if (destino > andar_q)                   estado_d = SUBINDO;
        else                                          estado_d = DESCENDO;
      end

      // Edges outside these two states are simply never looked at.
      SUBINDO, DESCENDO: begin
        motorSubindo  = (estado_q == SUBINDO);
        motorDescendo = (estado_q == DESCENDO);
        if (borda) estado_d = REGISTRA;
`ifdef UC_MOVIMENTO_WATCHDOG_EN
        else if (viagem_q == VIA_FIM) begin
          estado_d = ERRO;
          erro_d   = 1'b1;
        end else begin
          viagem_d = viagem_q + VIA_W'(1);
        end
`endif
      end

      REGISTRA: begin
        motorSubindo  = (dir_q == SOBE);
        motorDescendo = (dir_q == DESCE);
        if (dir_q == SOBE) begin
          if (andar_q != TOPO) andar_d = andar_q + ANDAR_W'(1);
        end else if (andar_q != '0) begin
          andar_d = andar_q - ANDAR_W'(1);
        end
        estado_d = CHECA;
      end

      CHECA: begin
        if (andar_q != destino_q) begin
          motorSubindo  = (dir_q == SOBE);
          motorDescendo = (dir_q == DESCE);
          estado_d      = (dir_q == SOBE) ? SUBINDO : DESCENDO;
        end else if (origem_q) begin
          estado_d = (carga_q < CAP) ? ENTRA : REJEITA;
        end else begin
          estado_d = SAI;
        end
      end

      ENTRA: begin
        coloca_objetos = 1'b1;
        carga_d        = carga_q + CARGA_W'(1);
        estado_d       = SHIFT;
      end

      // A drop with nothing on board still retires the request.
      SAI: begin
        if (carga_q != '0) begin
          tira_objetos = 1'b1;
          carga_d      = carga_q - CARGA_W'(1);
        end
        estado_d = SHIFT;
      end

      REJEITA: begin
        rejeita  = 1'b1;
        estado_d = SHIFT;
      end

      SHIFT: begin
        shift    = 1'b1;
        espera_d = '0;
        estado_d = AGUARDA;
      end

      AGUARDA: begin
        if (espera_q == ESP_FIM) estado_d = PROX_PEDIDO;
        else                     espera_d = espera_q + ESP_W'(1);
      end

`ifdef UC_MOVIMENTO_WATCHDOG_EN
      ERRO: if (iniciar) estado_d = INICIALIZA;
`endif

      default: estado_d = INICIAL;
    endcase
  end

  assign andar_atual = andar_q;
  assign carga       = carga_q;
  assign db_estado   = estado_q;
`ifdef UC_MOVIMENTO_WATCHDOG_EN
  assign erro        = erro_q;
`else
  assign erro        = 1'b0;
`endif

endmodule

// File: tb/tb_uc_movimento_multi.sv
// Self-checking bench for uc_movimento_multi: directed latency sequence,
// a request table, randomized requests against a floor/cargo model, reset
// mid-move and the travel watchdog (when UC_MOVIMENTO_WATCHDOG_EN is set).
module tb_uc_movimento_multi;

  localparam int NA  = 6;   // not a power of two, so out-of-range floors are encodable
  localparam int CAP = 4;
  localparam int ESP = 50;
  localparam int VIA = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [2:0] andar_inicial;
  logic       temDestino;
  logic [2:0] destino;
  logic       eh_origem;
  logic       sensorAndar;
  logic       shift, motorSubindo, motorDescendo, coloca_objetos, tira_objetos, rejeita;
  logic [2:0] andar_atual;
  logic [2:0] carga;
  logic       erro;
  logic [3:0] db_estado;

  logic plant_en, plant_s, man_s;
  assign sensorAndar = plant_en ? plant_s : man_s;

  int checks = 0;
  int errors = 0;

  uc_movimento_multi #(
    .NUM_ANDARES(NA), .CAPACIDADE(CAP), .T_ESPERA(ESP), .T_VIAGEM(VIA)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .andar_inicial(andar_inicial),
    .temDestino(temDestino), .destino(destino), .eh_origem(eh_origem),
    .sensorAndar(sensorAndar), .shift(shift), .motorSubindo(motorSubindo),
    .motorDescendo(motorDescendo), .coloca_objetos(coloca_objetos),
    .tira_objetos(tira_objetos), .rejeita(rejeita), .andar_atual(andar_atual),
    .carga(carga), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Elevator shaft: while any motor runs, produce one-cycle sensor pulses.
  initial begin
    plant_s = 1'b0;
    forever begin
      @(negedge clock);
      if (plant_en && (motorSubindo || motorDescendo)) begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
        plant_s = 1'b1;
        @(negedge clock);
        plant_s = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic init_dut(input logic [2:0] ai);
    andar_inicial = ai;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_prox();
    for (int i = 0; i < 200 && db_estado != 4'd2; i++) @(negedge clock);
  endtask

  // Observed outcome of one request.
  int g_andar, g_carga, n_col, n_tira, n_rej, n_shift, saw_up, saw_down, both, dwell;

  task automatic do_req(input logic [2:0] d, input logic o);
    bit done;
    n_col = 0; n_tira = 0; n_rej = 0; n_shift = 0;
    saw_up = 0; saw_down = 0; both = 0; dwell = 0; done = 0;
    wait_prox();
    destino = d; eh_origem = o; temDestino = 1'b1;
    @(negedge clock);
    temDestino = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (shift)          n_shift++;
      if (coloca_objetos) n_col++;
      if (tira_objetos)   n_tira++;
      if (rejeita)        n_rej++;
      if (motorSubindo)   saw_up = 1;
      if (motorDescendo)  saw_down = 1;
      if (motorSubindo && motorDescendo) both = 1;
      if (db_estado == 4'd11) dwell++;
      if (n_shift > 0 && db_estado == 4'd2) done = 1;
      else @(negedge clock);
    end
    if (!done) chk("req_timeout", 0, 1);
    g_andar = int'(andar_atual);
    g_carga = int'(carga);
  endtask

  task automatic check_req(input string t, input int ea, input int ec, input int ecol,
                           input int etira, input int erej, input int eup, input int edown);
    chk({t, "_andar"}, g_andar, ea);
    chk({t, "_carga"}, g_carga, ec);
    chk({t, "_coloca"}, n_col, ecol);
    chk({t, "_tira"}, n_tira, etira);
    chk({t, "_rejeita"}, n_rej, erej);
    chk({t, "_shift"}, n_shift, 1);
    chk({t, "_up"}, saw_up, eup);
    chk({t, "_down"}, saw_down, edown);
    chk({t, "_both_motors"}, both, 0);
    chk({t, "_dwell"}, dwell, ESP);
  endtask

  typedef struct {
    logic [2:0] dest;
    logic       orig;
    int e_andar, e_carga, e_col, e_tira, e_rej, e_up, e_down;
  } vec_t;

  vec_t tab[14];

  initial begin
    int m_andar, m_carga, cnt;
    int e_col, e_tira, e_rej, e_up, e_down;
    logic [2:0] d;
    logic o;

    // Starting from floor 5 with one object on board.
    tab[0]  = '{3'd0, 1'b0, 0, 0, 0, 1, 0, 0, 1};
    tab[1]  = '{3'd3, 1'b1, 3, 1, 1, 0, 0, 1, 0};
    tab[2]  = '{3'd3, 1'b1, 3, 2, 1, 0, 0, 0, 0};
    tab[3]  = '{3'd3, 1'b1, 3, 3, 1, 0, 0, 0, 0};
    tab[4]  = '{3'd3, 1'b1, 3, 4, 1, 0, 0, 0, 0};
    tab[5]  = '{3'd3, 1'b1, 3, 4, 0, 0, 1, 0, 0};
    tab[6]  = '{3'd6, 1'b1, 3, 4, 0, 0, 1, 0, 0};
    tab[7]  = '{3'd7, 1'b0, 3, 4, 0, 0, 1, 0, 0};
    tab[8]  = '{3'd1, 1'b0, 1, 3, 0, 1, 0, 0, 1};
    tab[9]  = '{3'd1, 1'b0, 1, 2, 0, 1, 0, 0, 0};
    tab[10] = '{3'd1, 1'b0, 1, 1, 0, 1, 0, 0, 0};
    tab[11] = '{3'd1, 1'b0, 1, 0, 0, 1, 0, 0, 0};
    tab[12] = '{3'd1, 1'b0, 1, 0, 0, 0, 0, 0, 0};
    tab[13] = '{3'd5, 1'b1, 5, 1, 1, 0, 0, 1, 0};

    reset = 1'b0; iniciar = 1'b0; andar_inicial = 3'd0; temDestino = 1'b1;
    destino = 3'd0; eh_origem = 1'b0; plant_en = 1'b0; man_s = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_estado", int'(db_estado), 0);
    chk("rst_andar", int'(andar_atual), 0);
    chk("rst_carga", int'(carga), 0);
    chk("rst_erro", int'(erro), 0);
    chk("rst_pulses", int'({shift, coloca_objetos, tira_objetos, rejeita}), 0);
    chk("rst_motors", int'({motorSubindo, motorDescendo}), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_ignores_request", int'(db_estado), 0);
    temDestino = 1'b0;

    // Out-of-range starting floor loads 0
    init_dut(3'd7);
    chk("init_invalid_estado", int'(db_estado), 2);
    chk("init_invalid_andar", int'(andar_atual), 0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    init_dut(3'd2);
    chk("init_andar", int'(andar_atual), 2);

    // Pick-up at floor 5 from 2 with hand-placed edges: latency and dwell
    destino = 3'd5; eh_origem = 1'b1; temDestino = 1'b1;
    @(negedge clock);
    temDestino = 1'b0;
    chk("lat_subindo", int'(db_estado), 3);
    chk("lat_motor_up", int'({motorSubindo, motorDescendo}), 2);
    @(negedge clock);
    chk("lat_no_edge_stays", int'(db_estado), 3);
    for (int k = 0; k < 3; k++) begin
      man_s = 1'b1;
      @(negedge clock);
      chk($sformatf("lat%0d_registra", k), int'(db_estado), 5);
      chk($sformatf("lat%0d_andar_hold", k), int'(andar_atual), 2 + k);
      chk($sformatf("lat%0d_motor", k), int'({motorSubindo, motorDescendo}), 2);
      man_s = 1'b0;
      @(negedge clock);
      chk($sformatf("lat%0d_checa", k), int'(db_estado), 6);
      chk($sformatf("lat%0d_andar", k), int'(andar_atual), 3 + k);
      @(negedge clock);
      if (k < 2) chk($sformatf("lat%0d_back_up", k), int'(db_estado), 3);
    end
    chk("lat_coloca", int'(coloca_objetos), 1);
    @(negedge clock);
    chk("lat_shift", int'(shift), 1);
    chk("lat_carga", int'(carga), 1);
    @(negedge clock);
    cnt = 0;
    while (db_estado == 4'd11 && cnt < 200) begin
      cnt++;
      @(negedge clock);
    end
    chk("lat_dwell", cnt, ESP);
    chk("lat_prox", int'(db_estado), 2);

    // iniciar outside INICIAL does nothing
    andar_inicial = 3'd0; iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    chk("iniciar_ignored_estado", int'(db_estado), 2);
    chk("iniciar_ignored_andar", int'(andar_atual), 5);

    // Request table with the shaft model moving the car
    plant_en = 1'b1;
    foreach (tab[i]) begin
      do_req(tab[i].dest, tab[i].orig);
      check_req($sformatf("row%0d", i), tab[i].e_andar, tab[i].e_carga, tab[i].e_col,
                tab[i].e_tira, tab[i].e_rej, tab[i].e_up, tab[i].e_down);
    end

    // Randomized requests against the floor/cargo model
    m_andar = 5; m_carga = 1;
    for (int n = 0; n < 40; n++) begin
      d = 3'($urandom_range(0, 7));
      o = 1'($urandom_range(0, 1));
      e_col = 0; e_tira = 0; e_rej = 0; e_up = 0; e_down = 0;
      if (int'(d) < NA) begin
        e_up   = (int'(d) > m_andar) ? 1 : 0;
        e_down = (int'(d) < m_andar) ? 1 : 0;
        m_andar = int'(d);
        if (o) begin
          if (m_carga < CAP) begin m_carga++; e_col = 1; end
          else e_rej = 1;
        end else if (m_carga > 0) begin
          m_carga--; e_tira = 1;
        end
      end else begin
        e_rej = 1;
      end
      do_req(d, o);
      check_req($sformatf("rnd%0d", n), m_andar, m_carga, e_col, e_tira, e_rej, e_up, e_down);
    end

    // Asynchronous reset in the middle of a move
    plant_en = 1'b0;
    wait_prox();
    destino = (m_andar == 0) ? 3'd5 : 3'd0; eh_origem = 1'b0; temDestino = 1'b1;
    @(negedge clock);
    temDestino = 1'b0;
    chk("midmove_motor_on", int'(motorSubindo | motorDescendo), 1);
    #2 reset = 1'b0;
    #1;
    chk("midmove_rst_estado", int'(db_estado), 0);
    chk("midmove_rst_andar", int'(andar_atual), 0);
    chk("midmove_rst_carga", int'(carga), 0);
    chk("midmove_rst_motors", int'({motorSubindo, motorDescendo}), 0);
    chk("midmove_rst_outs", int'({shift, coloca_objetos, tira_objetos, rejeita, erro}), 0);
    @(negedge clock);
    reset = 1'b1;
    init_dut(3'd2);

    // Travel with no floor edges
    destino = 3'd4; eh_origem = 1'b1; temDestino = 1'b1;
    @(negedge clock);
    temDestino = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && db_estado == 4'd3; i++) begin
      cnt++;
      @(negedge clock);
    end
`ifdef UC_MOVIMENTO_WATCHDOG_EN
    chk("wd_cycles", cnt, VIA);
    chk("wd_estado", int'(db_estado), 12);
    chk("wd_erro", int'(erro), 1);
    chk("wd_motors", int'({motorSubindo, motorDescendo}), 0);
    repeat (3) @(negedge clock);
    chk("wd_latched", int'({db_estado, erro}), (12 << 1) | 1);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    chk("wd_reinit_estado", int'(db_estado), 1);
    @(negedge clock);
    chk("wd_reinit_prox", int'(db_estado), 2);
    chk("wd_reinit_erro", int'(erro), 0);
`else
    chk("nowd_still_moving", cnt, 40);
    chk("nowd_estado", int'(db_estado), 3);
    chk("nowd_erro", int'(erro), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
